// File: rtl/writeback_block_pkg.sv
// Writeback stage shared definitions.
// Data-path width, reset value and data type for the pipeline stages.
package wb_pkg;

    localparam int WB_DATA_W = 8;
    localparam logic [WB_DATA_W-1:0] WB_RESET_VAL = 8'h00;

    typedef logic [WB_DATA_W-1:0] wb_data_t;

endpackage

// File: rtl/writeback_block_if.sv
// Writeback data bundle between the mux stage and the pipe register.
// Master drives the selected result, slave returns the registered one.
interface wb_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] mux_ans_dm;
    logic [WIDTH-1:0] ans_wb;

    modport master (
        output mux_ans_dm,
        input  ans_wb
    );

    modport slave (
        input  mux_ans_dm,
        output ans_wb
    );

endinterface

// File: rtl/writeback_block_pipe_reg.sv
// Writeback pipe register: one-cycle D register with synchronous reset.
// Captures the incoming result unmodified on every rising edge.
module wb_pipe_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic clk_i,
    input  logic rst_i,
    wb_if.slave  bus
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next value is the incoming result, bit for bit.
    always_comb begin
        data_d = bus.mux_ans_dm;
    end

    // Reset has priority over a new value at the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign bus.ans_wb = data_q;

endmodule

// File: rtl/writeback_block.sv
// Writeback stage: registers the data-memory mux result for the
// register file and forwarding logic.
module writeback_block
    import wb_pkg::*;
#(
    parameter int                DATA_W    = WB_DATA_W,
    parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(WB_RESET_VAL)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mux_ans_dm,
    output logic [DATA_W-1:0] ans_wb
);

    wb_if #(.WIDTH(DATA_W)) pipe ();

    assign pipe.mux_ans_dm = mux_ans_dm;
    assign ans_wb          = pipe.ans_wb;

    wb_pipe_reg #(
        .WIDTH   (DATA_W),
        .RST_VAL (RESET_VAL)
    ) u_pipe_reg (
        .clk_i (clk),
        .rst_i (reset),
        .bus   (pipe.slave)
    );

`ifndef SYNTHESIS
    logic chk_vld_q;

    // Arms the checks once the first edge has defined ans_wb.
    always_ff @(posedge clk) begin
        chk_vld_q <= 1'b1;
    end

    a_load: assert property (
        @(posedge clk) disable iff (chk_vld_q !== 1'b1)
        !$past(reset) |-> ans_wb == $past(mux_ans_dm)
    );

    a_reset: assert property (
        @(posedge clk) disable iff (chk_vld_q !== 1'b1)
        $past(reset) |-> ans_wb == RESET_VAL
    );
`endif

endmodule

// File: tb/tb_writeback_block.sv
// Testbench for writeback_block: directed scenarios then random traffic
// checked against a one-slot pipeline model.
module tb_writeback_block;
    import wb_pkg::*;

    logic     clk;
    logic     reset;
    wb_data_t model_q;
    int       tests;
    int       fails;

    wb_if #(.WIDTH(WB_DATA_W)) bus ();

    writeback_block #(
        .DATA_W    (WB_DATA_W),
        .RESET_VAL (WB_RESET_VAL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mux_ans_dm (bus.mux_ans_dm),
        .ans_wb     (bus.ans_wb)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    task automatic check(input string tag, input wb_data_t exp);
        tests++;
        assert (bus.ans_wb === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, bus.ans_wb, exp);
        end
    endtask

    // Drive inputs, take one rising edge, compare against the model.
    task automatic edge_step(input logic r, input wb_data_t d,
                             input string tag);
        reset = r;
        bus.mux_ans_dm = d;
        @(posedge clk);
        model_q = r ? WB_RESET_VAL : d;
        #1;
        check(tag, model_q);
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_q = '0;
        reset = 1'b1;
        bus.mux_ans_dm = 8'hFF;

        // Reset wins over 0xFF on the first edge.
        edge_step(1'b1, 8'hFF, "rst_first");

        // Reset released: nothing changes before the next edge.
        reset = 1'b0;
        #1;
        check("rel_hold", 8'h00);
        edge_step(1'b0, 8'hFF, "rel_load");

        // Reset between edges must not act before the edge.
        reset = 1'b1;
        #100;
        check("mid_rst_hold", 8'hFF);
        edge_step(1'b1, 8'hFF, "rst_again");
        edge_step(1'b1, 8'hFF, "rst_held");

        // New data under reset is ignored until reset drops.
        edge_step(1'b1, 8'h0F, "rst_0f");
        edge_step(1'b0, 8'h0F, "load_0f");

        // Toggling between edges: only the edge value is taken.
        bus.mux_ans_dm = 8'h55;
        #100;
        check("tog_55", 8'h0F);
        bus.mux_ans_dm = 8'hAA;
        #100;
        check("tog_aa", 8'h0F);
        bus.mux_ans_dm = 8'h55;
        #100;
        check("tog_55b", 8'h0F);
        edge_step(1'b0, 8'h55, "tog_cap");

        // Back-to-back values, one-cycle delay each.
        edge_step(1'b0, 8'h01, "seq_01");
        edge_step(1'b0, 8'h80, "seq_80");
        edge_step(1'b0, 8'hFF, "seq_ff");
        edge_step(1'b0, 8'h00, "seq_00");

        // Mid-operation reset clears a nonzero value.
        edge_step(1'b0, 8'hC3, "pre_c3");
        edge_step(1'b1, 8'h3C, "mid_clear");
        edge_step(1'b0, 8'h3C, "post_load");

        // Random traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            logic     r;
            wb_data_t d;
            r = ($urandom_range(0, 9) == 0);
            d = wb_data_t'($urandom);
            edge_step(r, d, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/writeback_block.md
WRITEBACK_BLOCK -- requirements
Module: writeback_block

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: width of the writeback data path.
REQ-002 The block SHALL have parameter RESET_VAL, default 8'h00: value loaded into ans_wb on reset.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port mux_ans_dm SHALL be an input, DATA_W bits: result selected by the data-memory stage mux (ALU result or memory load data).
REQ-006 Port ans_wb SHALL be an output, DATA_W bits: registered writeback result presented to the register file and forwarding logic.
REQ-007 The block SHALL use exactly one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-008 On each rising clk edge with reset=1, ans_wb SHALL load RESET_VAL (0x00).
REQ-009 On each rising clk edge with reset=0, ans_wb SHALL load mux_ans_dm.
REQ-010 Latency SHALL be exactly one clock: a value on mux_ans_dm at edge N SHALL appear on ans_wb after edge N and hold until edge N+1.
REQ-011 ans_wb SHALL be driven only from a register; there SHALL be no combinational path from mux_ans_dm or reset to ans_wb.
REQ-012 Changes to mux_ans_dm between rising edges SHALL NOT affect ans_wb until the next rising edge.
REQ-013 When reset and a new mux_ans_dm value are present at the same edge, reset SHALL win and ans_wb SHALL become RESET_VAL.
REQ-014 Reset asserted mid-operation SHALL clear ans_wb at the next rising edge regardless of prior contents; on deassertion, the first edge with reset=0 SHALL load mux_ans_dm.
REQ-015 All DATA_W bits SHALL pass unmodified: no sign extension, truncation or arithmetic.
REQ-016 There SHALL be no handshake; the block SHALL accept a new value every cycle.

Reset
REQ-017 Reset SHALL be sampled only on the rising edge of clk; asserting reset between edges SHALL NOT change ans_wb before the next edge.
REQ-018 ans_wb SHALL be the only state in the block and SHALL reset to RESET_VAL.
REQ-019 Before the first rising edge, ans_wb SHALL be treated as undefined; benches SHALL NOT check it.

Structure
REQ-020 Shared package wb_pkg SHALL hold the constants WB_DATA_W (8) and WB_RESET_VAL (8'h00) and the typedef wb_data_t (logic [WB_DATA_W-1:0]), for use by the pipeline stages.
REQ-021 The storage SHALL be a single sub-module, wb_pipe_reg, a parameterized (WIDTH, RST_VAL) synchronous-reset D register; writeback_block SHALL instantiate it once.
REQ-022 The block SHALL include simulation-only assertions checking that ans_wb equals the previous-cycle mux_ans_dm when reset was 0 in that cycle, and equals RESET_VAL when reset was 1 in that cycle.

Verification (clk period 1000 ns)
REQ-023 reset=1, mux_ans_dm=0xFF across first edge -> ans_wb=0x00.
REQ-024 reset falls to 0 with mux_ans_dm=0xFF -> ans_wb=0xFF after the next rising edge, not before it.
REQ-025 reset re-asserted to 1 while mux_ans_dm=0xFF -> ans_wb=0x00 at the next edge and held while reset=1.
REQ-026 mux_ans_dm changed to 0x0F while reset=1 -> ans_wb stays 0x00; after reset drops, the first edge -> 0x0F.
REQ-027 mux_ans_dm toggled 0x55->0xAA->0x55 between two edges -> only the value present at the edge is captured; no glitch on ans_wb.
REQ-028 Back-to-back sequence 0x01, 0x80, 0xFF, 0x00 on consecutive edges -> ans_wb shows the same sequence delayed by one cycle.
